// File: rtl/qu_pmem_loader.sv
// qu_pmem_loader: streams bytes into program memory as little-endian instruction words,
// holding the core stalled during the load and enabling scheduling after a settle delay.
`timescale 1ns/1ps
`default_nettype none

module qu_pmem_loader #(
    parameter int INSTR_WIDTH   = 32,
    parameter int PMEM_DEPTH    = 1024,
    parameter int RELEASE_DELAY = 4,
    localparam int AW           = $clog2(PMEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AW:0]            len,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   pmem_we,
    output logic [AW-1:0]          pmem_addr,
    output logic [INSTR_WIDTH-1:0] pmem_wdata,
    output logic                   core_stall,
    output logic                   schedule_en,
    output logic                   busy,
    output logic                   err
);

    localparam int BPW = INSTR_WIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int RCW = $clog2(RELEASE_DELAY + 1);
    localparam logic [AW:0]    LEN_MAX   = PMEM_DEPTH[AW:0];
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
    localparam logic [RCW-1:0] REL_LAST  = RCW'(RELEASE_DELAY);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [AW:0]            len_q;
    logic [AW:0]            word_cnt;
    logic [BCW-1:0]         byte_cnt;
    logic [INSTR_WIDTH-1:0] shreg;
    logic [RCW-1:0]         rel_cnt;
    logic [INSTR_WIDTH-1:0] word_next;
    logic                   len_ok;
    logic                   beat;
    logic                   last_byte;
    logic                   last_word;
    logic                   can_start;

    assign len_ok    = (len != '0) && (len <= LEN_MAX);
    assign beat      = s_valid && s_ready;
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign last_word = ((word_cnt + (AW+1)'(1)) == len_q);
    assign can_start = start && ((state == S_IDLE) || (state == S_RUN));

    // The final byte of a word bypasses the shift register so the write issues one cycle after the beat.
    always_comb begin
        word_next = shreg;
        word_next[8*byte_cnt +: 8] = s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        core_stall  = 1'b1;
        schedule_en = 1'b0;
        busy        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && len_ok) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (beat && last_byte && last_word) state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                core_stall = 1'b0;
                busy       = 1'b1;
                if (rel_cnt == REL_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                core_stall  = 1'b0;
                schedule_en = 1'b1;
                if (start && len_ok) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pmem_we    <= 1'b0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
            err        <= 1'b0;
            len_q      <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            rel_cnt    <= '0;
        end else begin
            pmem_we <= 1'b0;
            err     <= 1'b0;
            if (can_start) begin
                if (len_ok) begin
                    len_q    <= len;
                    word_cnt <= '0;
                    byte_cnt <= '0;
                    shreg    <= '0;
                end else begin
                    err <= 1'b1;
                end
            end
            if ((state == S_LOAD) && beat) begin
                if (last_byte) begin
                    pmem_we    <= 1'b1;
                    pmem_wdata <= word_next;
                    pmem_addr  <= word_cnt[AW-1:0];
                    word_cnt   <= word_cnt + (AW+1)'(1);
                    byte_cnt   <= '0;
                end else begin
                    shreg    <= word_next;
                    byte_cnt <= byte_cnt + BCW'(1);
                end
            end
            if (state == S_RELEASE) rel_cnt <= rel_cnt + RCW'(1);
            else                    rel_cnt <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_qu_pmem_loader.sv
// Scoreboard bench for qu_pmem_loader: expected pmem writes are queued from a byte-level
// model at stimulus time and a negedge monitor compares every pmem_we against them.
`timescale 1ns/1ps
`default_nettype none

module tb_qu_pmem_loader;

    localparam int INSTR_WIDTH   = 32;
    localparam int PMEM_DEPTH    = 1024;
    localparam int RELEASE_DELAY = 4;
    localparam int AW            = $clog2(PMEM_DEPTH);
    localparam int BPW           = INSTR_WIDTH / 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic [AW:0]            len = '0;
    logic [7:0]             s_data = 8'h00;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic                   pmem_we;
    logic [AW-1:0]          pmem_addr;
    logic [INSTR_WIDTH-1:0] pmem_wdata;
    logic                   core_stall;
    logic                   schedule_en;
    logic                   busy;
    logic                   err;

    qu_pmem_loader #(
        .INSTR_WIDTH  (INSTR_WIDTH),
        .PMEM_DEPTH   (PMEM_DEPTH),
        .RELEASE_DELAY(RELEASE_DELAY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .pmem_we    (pmem_we),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .core_stall (core_stall),
        .schedule_en(schedule_en),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          addr;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  last_we_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: word w is bytes w*BPW .. w*BPW+BPW-1, least significant byte first.
    task automatic model_load(input logic [7:0] b[$], input int nw);
        for (int w = 0; w < nw; w++) begin
            logic [63:0] d;
            d = 64'd0;
            for (int k = BPW - 1; k >= 0; k--) d = d * 256 + 64'(b[w*BPW + k]);
            exp_q.push_back('{addr: w, data: d});
        end
    endtask

    always @(negedge clk) begin
        if (rst && pmem_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_we: got addr %0d data %0h expected no write", pmem_addr, pmem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("we_addr", 64'(pmem_addr), 64'(mon_e.addr));
                chk("we_data", 64'(pmem_wdata), mon_e.data);
            end
            last_we_cyc = cyc;
        end
    end

    // Pulses start; on acceptance the DUT must stall the core and open the stream next cycle.
    task automatic issue_start(input int l, input bit ok);
        @(posedge clk); #1;
        start = 1'b1;
        len   = (AW+1)'(l);
        @(posedge clk); #1;
        start = 1'b0;
        if (ok) begin
            chk("start_stall", 64'(core_stall), 64'd1);
            chk("start_sched", 64'(schedule_en), 64'd0);
            chk("start_ready", 64'({busy, s_ready, err}), 64'b110);
        end else begin
            chk("bad_len_err", 64'({err, busy, s_ready}), 64'b100);
            @(posedge clk); #1;
            chk("err_one_cycle", 64'(err), 64'd0);
        end
    endtask

    // Offers bytes b[0..n-1]; mode 0 = every cycle, 1 = alternate cycles, 2 = random gaps.
    task automatic send_bytes(input logic [7:0] b[$], input int n, input int mode, output bit stall_ok);
        int  i = 0;
        int  guard = 0;
        bit  took;
        stall_ok = 1'b1;
        while (i < n && guard < 2000) begin
            guard++;
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = guard[0];
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = s_valid ? b[i] : 8'($urandom);
            @(negedge clk);
            took = s_valid && s_ready;
            if (!core_stall) stall_ok = 1'b0;
            @(posedge clk); #1;
            if (took) i++;
        end
        s_valid = 1'b0;
        if (i < n) chk("byte_timeout", 64'(i), 64'(n));
    endtask

    task automatic do_load(input logic [7:0] b[$], input int nw, input int mode);
        bit stall_ok;
        int guard;
        issue_start(nw, 1'b1);
        model_load(b, nw);
        send_bytes(b, nw * BPW, mode, stall_ok);
        chk("stall_during_load", 64'(stall_ok), 64'd1);
        chk("ready_drop", 64'({s_ready, core_stall, busy}), 64'b001);
        s_valid = 1'b1;
        s_data  = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        guard = 0;
        while (!schedule_en && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("sched_latency", 64'(cyc - last_we_cyc), 64'(RELEASE_DELAY + 1));
        chk("run_outputs", 64'({core_stall, busy, schedule_en}), 64'b001);
        chk("addr_hold", 64'(pmem_addr), 64'(nw - 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b[$];
        bit         dummy;
        int         nw;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({core_stall, s_ready, pmem_we, schedule_en, busy, err}), 64'b100000);
        chk("reset_addr", 64'(pmem_addr), 64'd0);
        chk("reset_wdata", 64'(pmem_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Bad lengths from IDLE must pulse err and write nothing.
        issue_start(0, 1'b0);
        issue_start(PMEM_DEPTH + 1, 1'b0);
        chk("idle_after_err", 64'({core_stall, busy, schedule_en}), 64'b100);

        b = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_load(b, 2, 0);
        do_load(b, 2, 1);

        issue_start(PMEM_DEPTH + 1, 1'b0);
        chk("run_after_err", 64'(schedule_en), 64'd1);

        b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_load(b, 1, 0);

        // Asynchronous reset while in RUN.
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("async_rst_run", 64'({core_stall, schedule_en, s_ready, pmem_we, busy}), 64'b10000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset three bytes into a word: nothing may be written.
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        issue_start(2, 1'b1);
        send_bytes(b, 3, 0, dummy);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_load", 64'({core_stall, schedule_en, s_ready, pmem_we}), 64'b1000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        b = '{8'h78, 8'h56, 8'h34, 8'h12};
        do_load(b, 1, 0);

        for (int it = 0; it < 8; it++) begin
            nw = int'($urandom_range(1, 6));
            b.delete();
            for (int k = 0; k < nw * BPW; k++) b.push_back(8'($urandom));
            do_load(b, nw, int'($urandom_range(0, 2)));
        end

        repeat (5) @(posedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
